// File: rtl/corebootstrap_ahb_pkg.sv
// rtl/corebootstrap_ahb_pkg.sv - shared AHB encodings and arbiter state types
package corebootstrap_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    DATA_M0  = 2'd1,
    DATA_M1  = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
  } ahb_ctrl_t;

  // NONSEQ and SEQ both carry a real transfer; SEQ is replayed as NONSEQ.
  function automatic logic is_active(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/corebootstrap_ahb_hold_stage.sv
// rtl/corebootstrap_ahb_hold_stage.sv - per-master address capture, pend flag and HREADY
module corebootstrap_ahb_hold_stage
  import corebootstrap_ahb_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic        done,
  output logic        hready,
  output logic        pend,
  output ahb_ctrl_t   hold
);

  logic cap;

  // Ready while empty, and in the completion cycle so the next address can be taken.
  assign hready = !pend || done;
  assign cap    = hready && is_active(htrans);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      pend <= 1'b0;
      hold <= '0;
    end else begin
      if (cap) begin
        hold <= '{addr: haddr, write: hwrite, size: hsize};
      end
      pend <= cap || (pend && !done);
    end
  end

endmodule

// File: rtl/corebootstrap_ahb_arbiter.sv
// rtl/corebootstrap_ahb_arbiter.sv - two-master AHB-Lite arbiter sharing one slave path
module corebootstrap_ahb_arbiter
  import corebootstrap_ahb_pkg::*;
#(
  parameter logic ROUND_ROBIN = 1'b1,
  parameter logic BOOT_LOCK   = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        sel_host,
  input  logic [31:0] M0_HADDR,
  input  logic [1:0]  M0_HTRANS,
  input  logic        M0_HWRITE,
  input  logic [2:0]  M0_HSIZE,
  input  logic [31:0] M0_HWDATA,
  output logic [31:0] M0_HRDATA,
  output logic        M0_HREADY,
  output logic        M0_HRESP,
  input  logic [31:0] M1_HADDR,
  input  logic [1:0]  M1_HTRANS,
  input  logic        M1_HWRITE,
  input  logic [2:0]  M1_HSIZE,
  input  logic [31:0] M1_HWDATA,
  output logic [31:0] M1_HRDATA,
  output logic        M1_HREADY,
  output logic        M1_HRESP,
  output logic [31:0] S_HADDR,
  output logic [1:0]  S_HTRANS,
  output logic        S_HWRITE,
  output logic [2:0]  S_HSIZE,
  output logic [2:0]  S_HBURST,
  output logic [31:0] S_HWDATA,
  input  logic [31:0] S_HRDATA,
  input  logic        S_HREADY,
  input  logic        S_HRESP,
  output logic        owner,
  output logic        busy
);

  arb_state_t state, state_nxt;
  logic       last_grant;
  logic       pend0, pend1, done0, done1, grant0, grant1, elig1;
  ahb_ctrl_t  hold0, hold1;

  corebootstrap_ahb_hold_stage u_hold_m0 (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .haddr  (M0_HADDR),
    .htrans (M0_HTRANS),
    .hwrite (M0_HWRITE),
    .hsize  (M0_HSIZE),
    .done   (done0),
    .hready (M0_HREADY),
    .pend   (pend0),
    .hold   (hold0)
  );

  corebootstrap_ahb_hold_stage u_hold_m1 (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .haddr  (M1_HADDR),
    .htrans (M1_HTRANS),
    .hwrite (M1_HWRITE),
    .hsize  (M1_HSIZE),
    .done   (done1),
    .hready (M1_HREADY),
    .pend   (pend1),
    .hold   (hold1)
  );

  assign elig1    = pend1 && (sel_host || !BOOT_LOCK);
  assign busy     = (state != ARB_IDLE);
  assign S_HBURST = HBURST_SINGLE;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state      <= ARB_IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant0) begin
        last_grant <= 1'b0;
        owner      <= 1'b0;
      end else if (grant1) begin
        last_grant <= 1'b1;
        owner      <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant0    = 1'b0;
    grant1    = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    S_HTRANS  = HTRANS_IDLE;
    S_HADDR   = '0;
    S_HWRITE  = 1'b0;
    S_HSIZE   = '0;
    S_HWDATA  = '0;
    M0_HRDATA = '0;
    M0_HRESP  = HRESP_OKAY;
    M1_HRDATA = '0;
    M1_HRESP  = HRESP_OKAY;
    case (state)
      ARB_IDLE: begin
        if (pend0 && elig1) begin
          if (ROUND_ROBIN && !last_grant) grant1 = 1'b1;
          else                            grant0 = 1'b1;
        end else if (pend0) begin
          grant0 = 1'b1;
        end else if (elig1) begin
          grant1 = 1'b1;
        end
        if (grant0) begin
          state_nxt = DATA_M0;
          S_HTRANS  = HTRANS_NONSEQ;
          S_HADDR   = hold0.addr;
          S_HWRITE  = hold0.write;
          S_HSIZE   = hold0.size;
        end else if (grant1) begin
          state_nxt = DATA_M1;
          S_HTRANS  = HTRANS_NONSEQ;
          S_HADDR   = hold1.addr;
          S_HWRITE  = hold1.write;
          S_HSIZE   = hold1.size;
        end
      end
      // Response passes through every data cycle so both ERROR cycles reach the master.
      DATA_M0: begin
        S_HWDATA  = M0_HWDATA;
        M0_HRDATA = S_HRDATA;
        M0_HRESP  = S_HRESP;
        if (S_HREADY) begin
          done0     = 1'b1;
          state_nxt = ARB_IDLE;
        end
      end
      DATA_M1: begin
        S_HWDATA  = M1_HWDATA;
        M1_HRDATA = S_HRDATA;
        M1_HRESP  = S_HRESP;
        if (S_HREADY) begin
          done1     = 1'b1;
          state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_corebootstrap_ahb_arbiter.sv
// tb/tb_corebootstrap_ahb_arbiter.sv - directed self-checking bench for the AHB arbiter
module tb_corebootstrap_ahb_arbiter;
  import corebootstrap_ahb_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESET, sel_host;
  logic [31:0] M0_HADDR, M0_HWDATA, M0_HRDATA, M1_HADDR, M1_HWDATA, M1_HRDATA;
  logic [1:0]  M0_HTRANS, M1_HTRANS, S_HTRANS;
  logic        M0_HWRITE, M1_HWRITE, M0_HREADY, M1_HREADY, M0_HRESP, M1_HRESP;
  logic [2:0]  M0_HSIZE, M1_HSIZE, S_HSIZE, S_HBURST;
  logic [31:0] S_HADDR, S_HWDATA, S_HRDATA;
  logic        S_HWRITE, S_HREADY, S_HRESP, owner, busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 HCLK = ~HCLK;

  corebootstrap_ahb_arbiter #(.ROUND_ROBIN(1'b1), .BOOT_LOCK(1'b1)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .sel_host(sel_host),
    .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE), .M0_HSIZE(M0_HSIZE),
    .M0_HWDATA(M0_HWDATA), .M0_HRDATA(M0_HRDATA), .M0_HREADY(M0_HREADY), .M0_HRESP(M0_HRESP),
    .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE), .M1_HSIZE(M1_HSIZE),
    .M1_HWDATA(M1_HWDATA), .M1_HRDATA(M1_HRDATA), .M1_HREADY(M1_HREADY), .M1_HRESP(M1_HRESP),
    .S_HADDR(S_HADDR), .S_HTRANS(S_HTRANS), .S_HWRITE(S_HWRITE), .S_HSIZE(S_HSIZE),
    .S_HBURST(S_HBURST), .S_HWDATA(S_HWDATA), .S_HRDATA(S_HRDATA), .S_HREADY(S_HREADY),
    .S_HRESP(S_HRESP), .owner(owner), .busy(busy)
  );

  // Slave: fixed wait states or a two-cycle ERROR, read data = ~address, logs every transfer.
  logic        sl_active, sl_err, sl_err_cur;
  int          sl_cnt, sl_wait, sl_idx;
  logic [31:0] sl_addr;
  logic [31:0] log_addr [64];
  logic [31:0] log_wdata [64];
  logic        log_write [64];
  int          n_log = 0;

  assign S_HREADY = !sl_active || (sl_cnt == 0);
  assign S_HRESP  = sl_active && sl_err_cur;
  assign S_HRDATA = sl_active ? ~sl_addr : 32'h0;

  always @(posedge HCLK) begin
    if (HRESET) begin
      sl_active  <= 1'b0;
      sl_cnt     <= 0;
      sl_err_cur <= 1'b0;
    end else begin
      if (sl_active) begin
        if (S_HREADY) begin
          sl_active         <= 1'b0;
          log_wdata[sl_idx] <= S_HWDATA;
        end else begin
          sl_cnt <= sl_cnt - 1;
        end
      end
      if (S_HTRANS == HTRANS_NONSEQ && S_HREADY) begin
        sl_active        <= 1'b1;
        sl_addr          <= S_HADDR;
        sl_err_cur       <= sl_err;
        sl_cnt           <= sl_err ? 1 : sl_wait;
        sl_idx           <= n_log;
        log_addr[n_log]  <= S_HADDR;
        log_write[n_log] <= S_HWRITE;
        n_log            <= n_log + 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic masters_idle();
    M0_HTRANS = HTRANS_IDLE; M0_HADDR = '0; M0_HWRITE = 1'b0; M0_HSIZE = 3'd2; M0_HWDATA = '0;
    M1_HTRANS = HTRANS_IDLE; M1_HADDR = '0; M1_HWRITE = 1'b0; M1_HSIZE = 3'd2; M1_HWDATA = '0;
  endtask

  function automatic logic [31:0] wdata_of(input int m, input int k);
    return 32'hD000_0000 | (32'(m) << 8) | 32'(k);
  endfunction

  // Pipelined AHB write masters: next address issued whenever the last edge saw HREADY=1.
  task automatic run_masters(input int n0, input int n1, input logic [31:0] b0,
                             input logic [31:0] b1, output int cycles);
    int a_idx[2], d_idx[2], issued[2], done[2], n[2];
    bit a_v[2], d_v[2], r[2];
    n[0] = n0; n[1] = n1; cycles = -1;
    for (int m = 0; m < 2; m++) begin
      a_idx[m] = 0; d_idx[m] = 0; issued[m] = 0; done[m] = 0;
      a_v[m] = 1'b0; d_v[m] = 1'b0; r[m] = 1'b1;
    end
    for (int c = 0; c < 200; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (r[m]) begin
          if (d_v[m]) done[m]++;
          d_v[m] = a_v[m]; d_idx[m] = a_idx[m];
          if (issued[m] < n[m]) begin
            a_v[m] = 1'b1; a_idx[m] = issued[m]; issued[m]++;
          end else begin
            a_v[m] = 1'b0;
          end
        end
      end
      M0_HTRANS = a_v[0] ? HTRANS_NONSEQ : HTRANS_IDLE;
      M0_HADDR  = b0 + 32'(4 * a_idx[0]);
      M0_HWRITE = 1'b1;
      M0_HWDATA = d_v[0] ? wdata_of(0, d_idx[0]) : 32'h0;
      M1_HTRANS = a_v[1] ? HTRANS_NONSEQ : HTRANS_IDLE;
      M1_HADDR  = b1 + 32'(4 * a_idx[1]);
      M1_HWRITE = 1'b1;
      M1_HWDATA = d_v[1] ? wdata_of(1, d_idx[1]) : 32'h0;
      if (done[0] == n0 && done[1] == n1) begin
        cycles = c;
        break;
      end
      #1;
      r[0] = M0_HREADY; r[1] = M1_HREADY;
      tick();
    end
  endtask

  int base, cyc;

  initial begin
    HRESET = 1'b1; sel_host = 1'b0; sl_err = 1'b0; sl_wait = 0;
    masters_idle();
    tick(); tick();
    HRESET = 1'b0;
    #1;
    check_eq("rst_m0_hready", 32'(M0_HREADY), 32'd1);
    check_eq("rst_m1_hready", 32'(M1_HREADY), 32'd1);
    check_eq("rst_m0_hresp", 32'(M0_HRESP), 32'd0);
    check_eq("rst_m1_hresp", 32'(M1_HRESP), 32'd0);
    check_eq("rst_m0_hrdata", M0_HRDATA, 32'h0);
    check_eq("rst_m1_hrdata", M1_HRDATA, 32'h0);
    check_eq("rst_s_htrans", 32'(S_HTRANS), 32'(HTRANS_IDLE));
    check_eq("rst_s_haddr", S_HADDR, 32'h0);
    check_eq("rst_s_hwrite", 32'(S_HWRITE), 32'd0);
    check_eq("rst_s_hburst", 32'(S_HBURST), 32'd0);
    check_eq("rst_owner", 32'(owner), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);

    // Boot-time M0 write, zero-wait slave
    base = n_log;
    M0_HTRANS = HTRANS_NONSEQ; M0_HADDR = 32'h2000_0000; M0_HWRITE = 1'b1; M0_HSIZE = 3'd2;
    #1; check_eq("t1_addr_hready", 32'(M0_HREADY), 32'd1);
    tick();
    M0_HTRANS = HTRANS_IDLE; M0_HWDATA = 32'hDEAD_BEEF;
    #1;
    check_eq("t1_s_htrans", 32'(S_HTRANS), 32'(HTRANS_NONSEQ));
    check_eq("t1_s_haddr", S_HADDR, 32'h2000_0000);
    check_eq("t1_s_hwrite", 32'(S_HWRITE), 32'd1);
    check_eq("t1_s_hsize", 32'(S_HSIZE), 32'd2);
    check_eq("t1_wait_hready", 32'(M0_HREADY), 32'd0);
    tick(); #1;
    check_eq("t1_done_hready", 32'(M0_HREADY), 32'd1);
    check_eq("t1_s_hwdata", S_HWDATA, 32'hDEAD_BEEF);
    check_eq("t1_owner", 32'(owner), 32'd0);
    check_eq("t1_busy", 32'(busy), 32'd1);
    tick(); #1;
    check_eq("t1_log_wdata", log_wdata[base], 32'hDEAD_BEEF);
    check_eq("t1_busy_after", 32'(busy), 32'd0);

    // M1 read locked out until handoff
    M1_HTRANS = HTRANS_NONSEQ; M1_HADDR = 32'h8000_0004; M1_HWRITE = 1'b0;
    #1; tick();
    M1_HTRANS = HTRANS_IDLE;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("t2_m1_stalled", 32'(M1_HREADY), 32'd0);
      check_eq("t2_s_idle", 32'(S_HTRANS), 32'(HTRANS_IDLE));
      tick();
    end
    sel_host = 1'b1;
    #1;
    check_eq("t2_s_htrans", 32'(S_HTRANS), 32'(HTRANS_NONSEQ));
    check_eq("t2_s_haddr", S_HADDR, 32'h8000_0004);
    check_eq("t2_s_hwrite", 32'(S_HWRITE), 32'd0);
    tick(); #1;
    check_eq("t2_m1_hready", 32'(M1_HREADY), 32'd1);
    check_eq("t2_m1_hrdata", M1_HRDATA, 32'h7FFF_FFFB);
    check_eq("t2_owner", 32'(owner), 32'd1);
    check_eq("t2_m0_hrdata", M0_HRDATA, 32'h0);
    tick();

    // Two-cycle ERROR on an M0 read
    sl_err = 1'b1;
    M0_HTRANS = HTRANS_NONSEQ; M0_HADDR = 32'h3000_0000; M0_HWRITE = 1'b0;
    #1; tick();
    M0_HTRANS = HTRANS_IDLE;
    #1; check_eq("t4_s_htrans", 32'(S_HTRANS), 32'(HTRANS_NONSEQ));
    tick(); #1;
    check_eq("t4_err1_hready", 32'(M0_HREADY), 32'd0);
    check_eq("t4_err1_hresp", 32'(M0_HRESP), 32'd1);
    check_eq("t4_m1_hready", 32'(M1_HREADY), 32'd1);
    check_eq("t4_m1_hresp", 32'(M1_HRESP), 32'd0);
    tick();
    sl_err = 1'b0;
    #1;
    check_eq("t4_err2_hready", 32'(M0_HREADY), 32'd1);
    check_eq("t4_err2_hresp", 32'(M0_HRESP), 32'd1);
    check_eq("t4_err2_hrdata", M0_HRDATA, 32'hCFFF_FFFF);
    tick(); #1;
    check_eq("t4_after_hresp", 32'(M0_HRESP), 32'd0);

    // Four back-to-back M0 writes against a 2-wait-state slave
    sl_wait = 2;
    base = n_log;
    run_masters(4, 0, 32'h4000_0000, 32'h0, cyc);
    check_eq("t5_cycles", 32'(cyc), 32'd17);
    tick(); #1;
    check_eq("t5_count", 32'(n_log - base), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check_eq("t5_addr", log_addr[base + k], 32'h4000_0000 + 32'(4 * k));
      check_eq("t5_wdata", log_wdata[base + k], wdata_of(0, k));
    end

    // Reset in the middle of an M1 data phase
    sl_wait = 3;
    M1_HTRANS = HTRANS_NONSEQ; M1_HADDR = 32'h9000_0000; M1_HWRITE = 1'b0;
    #1; tick();
    M1_HTRANS = HTRANS_IDLE;
    tick(); #1;
    check_eq("t6_busy", 32'(busy), 32'd1);
    check_eq("t6_owner", 32'(owner), 32'd1);
    check_eq("t6_m1_wait", 32'(M1_HREADY), 32'd0);
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    #1;
    check_eq("t6_m1_hready", 32'(M1_HREADY), 32'd1);
    check_eq("t6_m1_hrdata", M1_HRDATA, 32'h0);
    check_eq("t6_m1_hresp", 32'(M1_HRESP), 32'd0);
    check_eq("t6_s_htrans", 32'(S_HTRANS), 32'(HTRANS_IDLE));
    check_eq("t6_s_haddr", S_HADDR, 32'h0);
    check_eq("t6_busy_rst", 32'(busy), 32'd0);
    check_eq("t6_owner_rst", 32'(owner), 32'd0);
    tick(); #1;
    check_eq("t6_s_idle_after", 32'(S_HTRANS), 32'(HTRANS_IDLE));

    // Round-robin with both masters streaming writes; reset left M0 winning the first tie
    sl_wait = 0;
    base = n_log;
    run_masters(4, 4, 32'h1000_0000, 32'h5000_0000, cyc);
    check_eq("t3_cycles", 32'(cyc), 32'd17);
    tick(); #1;
    check_eq("t3_count", 32'(n_log - base), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check_eq("t3_addr", log_addr[base + i],
               ((i % 2) ? 32'h5000_0000 : 32'h1000_0000) + 32'(4 * (i / 2)));
      check_eq("t3_wdata", log_wdata[base + i], wdata_of(i % 2, i / 2));
      check_eq("t3_write", 32'(log_write[base + i]), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/corebootstrap_ahb_arbiter.md
Name: corebootstrap_ahb_arbiter

Overview:
This block is a two-master AHB-Lite arbiter that shares one AHB slave path (boot memory / fabric) between the bootstrap writer (M0) and the processor host (M1).
- While boot copy is in progress (sel_host=0), only M0 is serviced.
- After handoff (sel_host=1), both masters are serviced by round-robin or fixed priority.
- Each master sees a standard AHB-Lite slave. Transfers are captured in a per-master hold stage and replayed to the slave as single NONSEQ transfers, one outstanding at a time.

Parameters:
ROUND_ROBIN, 1, 1 = alternate M0/M1 when both are pending; 0 = M0 always wins.
BOOT_LOCK, 1, 1 = M1 is stalled while sel_host=0; 0 = ignore sel_host.

Ports:
HCLK  in  1  system clock.
HRESET  in  1  synchronous, active-high reset.
sel_host  in  1  handoff flag from the bootstrap writer.
M0_HADDR/M1_HADDR  in  32  master address.
M0_HTRANS/M1_HTRANS  in  2  master transfer type.
M0_HWRITE/M1_HWRITE  in  1  master write strobe.
M0_HSIZE/M1_HSIZE  in  3  master transfer size.
M0_HWDATA/M1_HWDATA  in  32  master write data.
M0_HRDATA/M1_HRDATA  out  32  read data returned to master.
M0_HREADY/M1_HREADY  out  1  ready returned to master.
M0_HRESP/M1_HRESP  out  1  response returned to master.
S_HADDR  out  32  slave address.
S_HTRANS  out  2  slave transfer type.
S_HWRITE  out  1  slave write strobe.
S_HSIZE  out  3  slave transfer size.
S_HBURST  out  3  slave burst type.
S_HWDATA  out  32  slave write data.
S_HRDATA  in  32  slave read data.
S_HREADY  in  1  slave ready.
S_HRESP  in  1  slave response.
owner  out  1  master owning the current or last slave transfer (0=M0, 1=M1).
busy  out  1  slave data phase in progress.

Behaviour:
- Reset values (synchronous on HRESET=1):
  - both pend flags = 0, state = ARB_IDLE, last-grant = M1 (so M0 wins the first tie).
  - Mx_HREADY = 1, Mx_HRESP = 0, Mx_HRDATA = 0.
  - S_HTRANS = IDLE, S_HADDR = 0, S_HWRITE = 0.
  - owner = 0, busy = 0.
- Hold stage (per master):
  - Capture condition: Mx_HREADY=1 and Mx_HTRANS[1]=1 (NONSEQ or SEQ) → latch HADDR/HWRITE/HSIZE and set pend.
  - IDLE/BUSY transfers are not captured and receive a zero-wait OKAY.
  - Mx_HREADY = !pend, except it is 1 in that master's completion cycle.
  - A new address presented in the completion cycle is captured, and pend stays 1.
- Slave side:
  - S_HBURST = SINGLE always, S_HSIZE from the hold register.
  - SEQ is converted to NONSEQ.
  - S_HTRANS is NONSEQ only in the ARB_IDLE cycle in which a grant is made; otherwise IDLE.
- FSM states: ARB_IDLE, DATA_M0, DATA_M1.
  - ARB_IDLE → DATA_x when eligible pend_x is set; drive S_HADDR from hold_x; owner ← x.
  - M1 is eligible only if sel_host=1 or BOOT_LOCK=0.
  - Both eligible: ROUND_ROBIN=1 picks the master that is not last-grant; ROUND_ROBIN=0 picks M0.
  - DATA_x: S_HWDATA = Mx_HWDATA (the master holds it stable because its HREADY is low); busy=1.
  - On S_HREADY=1: Mx_HRDATA ← S_HRDATA, Mx_HRESP ← S_HRESP, Mx_HREADY=1 for that cycle, clear pend_x unless recaptured, → ARB_IDLE.
- Error response: S_HRESP is passed to Mx_HRESP in every DATA_x cycle, so the first ERROR cycle (HREADY=0) and the second ERROR cycle (HREADY=1) both reach the master.
- Latency: address phase at T → slave address at T+1 → completion no earlier than T+2, i.e. one added wait state per transfer.
- sel_host is sampled only in ARB_IDLE. A 0→1 change during DATA_M0 takes effect at the next arbitration.
- Non-owner HRDATA = 0; non-owner HRESP = 0.
- Mid-transfer HRESET aborts the slave transfer. The slave is assumed reset by the same HRESET.

Decomposition:
- Shared package corebootstrap_ahb_pkg holds:
  - HTRANS encodings IDLE/BUSY/NONSEQ/SEQ.
  - HBURST SINGLE.
  - HRESP OKAY/ERROR.
  - FSM state encodings.
- Sub-module corebootstrap_ahb_hold_stage contains the capture register, pend flag and HREADY generation. It is instantiated once per master.

Test Plan:
- M0 write 0x2000_0000←0xDEADBEEF, zero-wait slave, sel_host=0 → S_HTRANS NONSEQ at T+1, M0_HREADY=1 at T+2, owner=0.
- sel_host=0, M1 read 0x8000_0004 while M0 idle → M1_HREADY held 0 indefinitely. Raise sel_host → read completes, M1_HRDATA = slave data.
- sel_host=1, ROUND_ROBIN=1, both masters issue continuous writes → slave grants alternate M0,M1,M0,M1; no transfer is lost.
- Slave returns two-cycle ERROR on M0 read → M0_HRESP=1 in both cycles, M0_HREADY=0 then 1; M1 is unaffected.
- M0 issues 4 back-to-back NONSEQ with 2-wait-state slave → S_HADDR sequence base+0/4/8/C; each completion recaptures the next address.
- HRESET asserted during DATA_M1 → next cycle all outputs are at reset values, pend=0, S_HTRANS=IDLE.
